alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Sequential front-end controller for the 4-bit ALU on the TP1 board.
- Captures operand A, operand B and the 6-bit opcode from the board switches on three push-buttons, in a fixed order, and drives them onto the ALU inputs.
- Samples the ALU result and holds it on the LEDs with a valid flag.
- Rejects opcodes the ALU does not implement.

Parameters:
- DATA_W, 4, operand/result width; must equal ALU data width.
- OP_W, 6, opcode width; switch bus width; OP_W >= DATA_W.
- DEBOUNCE_CYCLES, 500000, stable-level cycles required per button (used only with the optional feature).

Ports:
- clk  in  1  system clock; all state on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_sw  in  OP_W  board switches; operands use i_sw[DATA_W-1:0], opcode uses all OP_W bits.
- i_btn_a  in  1  load-A button, asynchronous, active-high.
- i_btn_b  in  1  load-B button, asynchronous, active-high.
- i_btn_op  in  1  load-opcode button, asynchronous, active-high.
- o_alu_a  out  DATA_W  registered operand A to ALU.
- o_alu_b  out  DATA_W  registered operand B to ALU.
- o_alu_op  out  OP_W  registered opcode to ALU.
- i_alu_result  in  DATA_W  combinational ALU result.
- o_leds  out  DATA_W  held result.
- o_valid  out  1  high while o_leds holds a result for the current operand set.
- o_err  out  1  last opcode load attempt was illegal.
- o_state  out  3  one-hot FSM status for board LEDs: [0] LOAD_A, [1] LOAD_B, [2] LOAD_OP; all zero in EXEC/SHOW.

Behaviour:
- Reset (async assert, sync deassert via clk):
  - All outputs 0.
  - FSM = LOAD_A.
  - Synchronizer and edge flops cleared.
- Button conditioning per button:
  - 2-flop synchronizer, then rising-edge detect: pulse = s2 & ~s2_d.
  - One pulse per press; holding a button gives no repeat.
- Load latency: with i_btn first sampled high at edge t0, the target register updates at edge t2.
- FSM states: LOAD_A, LOAD_B, LOAD_OP, EXEC, SHOW.
  - LOAD_A: on a_pulse, o_alu_a <= i_sw[DATA_W-1:0], clear o_err, go to LOAD_B.
  - LOAD_B: on b_pulse, o_alu_b <= i_sw[DATA_W-1:0], go to LOAD_OP.
  - LOAD_OP, legal opcode on op_pulse: o_alu_op <= i_sw, o_err <= 0, go to EXEC.
  - LOAD_OP, illegal opcode on op_pulse: o_alu_op unchanged, o_err <= 1, stay in LOAD_OP.
  - Legal opcodes: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 000011 SRA, 000010 SRL, 100111 NOR.
  - EXEC (exactly 1 cycle): ALU inputs have been stable one full cycle; o_leds <= i_alu_result, o_valid <= 1, go to SHOW.
  - SHOW: hold o_leds and o_valid. On a_pulse: load A, o_valid <= 0, go to LOAD_B. Pulses of b and op are ignored.
- o_valid falls the same edge A is reloaded. o_leds keeps the old result until the next EXEC.
- Pulses from buttons not expected in the current state are dropped, not queued.
- Simultaneous pulses: only the button matching the current state acts; the others are discarded.
- Reset mid-sequence: immediate return to LOAD_A with all registers 0; partial loads are lost.
- Result width: the ALU result is taken as DATA_W bits; carry/borrow is discarded (wrap-around mod 2^DATA_W).

Optional Feature:
- Macro ALU_SEQ_DEBOUNCE_EN.
- Defined:
  - Each synchronized button feeds a counter of width clog2(DEBOUNCE_CYCLES+1).
  - The debounced level updates only after s2 differs from it for DEBOUNCE_CYCLES consecutive cycles; the counter resets on any bounce.
  - Edge detect acts on the debounced level. Load latency becomes t0 + DEBOUNCE_CYCLES + 2 edges.
- Undefined: no counter logic; latency is exactly as in Behaviour; DEBOUNCE_CYCLES is ignored.

Test Plan:
- Reset, then press A with sw=0x05, B with sw=0x03, OP with sw=6'b100000 → o_alu_a=5, o_alu_b=3; one cycle after EXEC, o_leds=4'b1000 and o_valid=1.
- A=3, B=5, OP=6'b100010 (SUB) → o_leds=4'b1110 (wrap-around), o_valid=1.
- In LOAD_OP press OP with sw=6'b111111 → o_err=1, state stays LOAD_OP, o_alu_op unchanged; then sw=6'b100111 (NOR) with A=4'b1010, B=4'b0101 → o_err=0, o_leds=4'b0000.
- In LOAD_A press B and OP (alone, then together with A) → only A loads; o_alu_b and o_alu_op unchanged; state goes LOAD_B.
- Hold i_btn_a high 20 cycles → exactly one load, at edge t2 (macro undefined).
- Assert i_rst_n=0 mid-way through LOAD_OP, asynchronously between clock edges → all outputs 0 before the next edge, state LOAD_A. With ALU_SEQ_DEBOUNCE_EN and DEBOUNCE_CYCLES=8: a 3-cycle glitch causes no load; a 10-cycle press gives one load at t0+10.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: button-driven operand/opcode loader and result holder for the TP1 4-bit ALU.
// Optional per-button debounce filter is compiled in when ALU_SEQ_DEBOUNCE_EN is defined.
module alu_op_sequencer #(
  parameter int DATA_W          = 4,
  parameter int OP_W            = 6,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic [OP_W-1:0]   i_sw,
  input  logic              i_btn_a,
  input  logic              i_btn_b,
  input  logic              i_btn_op,
  output logic [DATA_W-1:0] o_alu_a,
  output logic [DATA_W-1:0] o_alu_b,
  output logic [OP_W-1:0]   o_alu_op,
  input  logic [DATA_W-1:0] i_alu_result,
  output logic [DATA_W-1:0] o_leds,
  output logic              o_valid,
  output logic              o_err,
  output logic [2:0]        o_state
);

  typedef enum logic [2:0] {
    ST_LOAD_A  = 3'd0,
    ST_LOAD_B  = 3'd1,
    ST_LOAD_OP = 3'd2,
    ST_EXEC    = 3'd3,
    ST_SHOW    = 3'd4
  } state_t;

  // Opcodes the ALU actually implements; everything else is rejected.
  function automatic logic op_legal(input logic [OP_W-1:0] op);
    logic ok_s;
    case (op)
      OP_W'(6'b100000), OP_W'(6'b100010), OP_W'(6'b100100), OP_W'(6'b100101),
      OP_W'(6'b100110), OP_W'(6'b000011), OP_W'(6'b000010), OP_W'(6'b100111):
        ok_s = 1'b1;
      default:
        ok_s = 1'b0;
    endcase
    return ok_s;
  endfunction

  // Button bit order everywhere: [0] A, [1] B, [2] OP.
  logic [2:0] sync1_r;
  logic [2:0] sync2_r;
  logic [2:0] level_d_r;
  logic [2:0] level_s;
  logic [2:0] pulse_s;

  state_t            state_r, state_nxt_s;
  logic [DATA_W-1:0] alu_a_r, alu_a_nxt_s;
  logic [DATA_W-1:0] alu_b_r, alu_b_nxt_s;
  logic [OP_W-1:0]   alu_op_r, alu_op_nxt_s;
  logic [DATA_W-1:0] leds_r, leds_nxt_s;
  logic              valid_r, valid_nxt_s;
  logic              err_r, err_nxt_s;
  logic [2:0]        state_vec_r, state_vec_nxt_s;

  // Two-flop synchronizer plus delayed copy of the conditioned level for edge detection.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_r   <= 3'b000;
      sync2_r   <= 3'b000;
      level_d_r <= 3'b000;
    end else begin
      sync1_r   <= {i_btn_op, i_btn_b, i_btn_a};
      sync2_r   <= sync1_r;
      level_d_r <= level_s;
    end
  end

`ifdef ALU_SEQ_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] db_cnt_r [3];
  logic [2:0]       db_level_r;

  // Debounce: the level follows s2 only after it has differed for DEBOUNCE_CYCLES cycles in a row.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      db_level_r <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        db_cnt_r[i] <= {CNT_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync2_r[i] != db_level_r[i]) begin
          if (db_cnt_r[i] == CNT_LAST) begin
            db_level_r[i] <= sync2_r[i];
            db_cnt_r[i]   <= {CNT_W{1'b0}};
          end else begin
            db_cnt_r[i] <= db_cnt_r[i] + CNT_W'(1);
          end
        end else begin
          db_cnt_r[i] <= {CNT_W{1'b0}};
        end
      end
    end
  end

  assign level_s = db_level_r;
`else
  assign level_s = sync2_r;
`endif

  assign pulse_s = level_s & ~level_d_r;

  // Next-state and next-output logic; pulses not meaningful in the current state are dropped.
  always_comb begin
    state_nxt_s  = state_r;
    alu_a_nxt_s  = alu_a_r;
    alu_b_nxt_s  = alu_b_r;
    alu_op_nxt_s = alu_op_r;
    leds_nxt_s   = leds_r;
    valid_nxt_s  = valid_r;
    err_nxt_s    = err_r;
    case (state_r)
      ST_LOAD_A: begin
        if (pulse_s[0]) begin
          alu_a_nxt_s = i_sw[DATA_W-1:0];
          err_nxt_s   = 1'b0;
          state_nxt_s = ST_LOAD_B;
        end else begin
          state_nxt_s = ST_LOAD_A;
        end
      end
      ST_LOAD_B: begin
        if (pulse_s[1]) begin
          alu_b_nxt_s = i_sw[DATA_W-1:0];
          state_nxt_s = ST_LOAD_OP;
        end else begin
          state_nxt_s = ST_LOAD_B;
        end
      end
      ST_LOAD_OP: begin
        if (pulse_s[2] && op_legal(i_sw)) begin
          alu_op_nxt_s = i_sw;
          err_nxt_s    = 1'b0;
          state_nxt_s  = ST_EXEC;
        end else if (pulse_s[2]) begin
          err_nxt_s   = 1'b1;
          state_nxt_s = ST_LOAD_OP;
        end else begin
          state_nxt_s = ST_LOAD_OP;
        end
      end
      ST_EXEC: begin
        // ALU inputs have been stable for a full cycle by now.
        leds_nxt_s  = i_alu_result;
        valid_nxt_s = 1'b1;
        state_nxt_s = ST_SHOW;
      end
      ST_SHOW: begin
        if (pulse_s[0]) begin
          alu_a_nxt_s = i_sw[DATA_W-1:0];
          valid_nxt_s = 1'b0;
          err_nxt_s   = 1'b0;
          state_nxt_s = ST_LOAD_B;
        end else begin
          state_nxt_s = ST_SHOW;
        end
      end
      default: begin
        state_nxt_s = ST_LOAD_A;
      end
    endcase
  end

  // One-hot status for the board LEDs, derived from the next state so it is registered with it.
  always_comb begin
    state_vec_nxt_s = 3'b000;
    case (state_nxt_s)
      ST_LOAD_A:  state_vec_nxt_s = 3'b001;
      ST_LOAD_B:  state_vec_nxt_s = 3'b010;
      ST_LOAD_OP: state_vec_nxt_s = 3'b100;
      default:    state_vec_nxt_s = 3'b000;
    endcase
  end

  // State and output registers; reset shows LOAD_A on the status LEDs.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r     <= ST_LOAD_A;
      alu_a_r     <= {DATA_W{1'b0}};
      alu_b_r     <= {DATA_W{1'b0}};
      alu_op_r    <= {OP_W{1'b0}};
      leds_r      <= {DATA_W{1'b0}};
      valid_r     <= 1'b0;
      err_r       <= 1'b0;
      state_vec_r <= 3'b001;
    end else begin
      state_r     <= state_nxt_s;
      alu_a_r     <= alu_a_nxt_s;
      alu_b_r     <= alu_b_nxt_s;
      alu_op_r    <= alu_op_nxt_s;
      leds_r      <= leds_nxt_s;
      valid_r     <= valid_nxt_s;
      err_r       <= err_nxt_s;
      state_vec_r <= state_vec_nxt_s;
    end
  end

  assign o_alu_a  = alu_a_r;
  assign o_alu_b  = alu_b_r;
  assign o_alu_op = alu_op_r;
  assign o_leds   = leds_r;
  assign o_valid  = valid_r;
  assign o_err    = err_r;
  assign o_state  = state_vec_r;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: cycle model of the load sequence plus directed literal checks.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] sw = 6'b000000;
  logic       btn_a = 1'b0, btn_b = 1'b0, btn_op = 1'b0;
  logic [3:0] alu_a, alu_b, alu_result, leds;
  logic [5:0] alu_op;
  logic       valid, err;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  alu_op_sequencer dut (
    .clk(clk), .i_rst_n(rst_n), .i_sw(sw),
    .i_btn_a(btn_a), .i_btn_b(btn_b), .i_btn_op(btn_op),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op),
    .i_alu_result(alu_result), .o_leds(leds), .o_valid(valid),
    .o_err(err), .o_state(state)
  );

  always #5 clk = ~clk;

  // Reference 4-bit ALU behaviour.
  function automatic logic [3:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [5:0] op);
    logic [3:0] r;
    case (op)
      6'b100000: r = a + b;
      6'b100010: r = a - b;
      6'b100100: r = a & b;
      6'b100101: r = a | b;
      6'b100110: r = a ^ b;
      6'b000011: r = 4'($signed(a) >>> b);
      6'b000010: r = a >> b;
      6'b100111: r = ~(a | b);
      default:   r = 4'b0000;
    endcase
    return r;
  endfunction

  assign alu_result = alu_f(alu_a, alu_b, alu_op);

  logic [5:0] legal_list [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                 6'b100110, 6'b000011, 6'b000010, 6'b100111};

  function automatic bit is_legal(input logic [5:0] op);
    bit found = 1'b0;
    for (int k = 0; k < 8; k++) if (legal_list[k] == op) found = 1'b1;
    return found;
  endfunction

  // Model: phase 0..4 = LOAD_A, LOAD_B, LOAD_OP, EXEC, SHOW. A press sampled at edge t acts at t+2.
  int         m_phase = 0;
  logic [3:0] m_a = 4'h0, m_b = 4'h0, m_leds = 4'h0;
  logic [5:0] m_op = 6'h00;
  logic       m_valid = 1'b0, m_err = 1'b0;
  logic [2:0] h0 = 3'b000, h1 = 3'b000, h2 = 3'b000;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_a = 4'h0; m_b = 4'h0; m_op = 6'h00; m_leds = 4'h0;
      m_valid = 1'b0; m_err = 1'b0; h0 = 3'b000; h1 = 3'b000; h2 = 3'b000;
    end else begin
      logic [2:0] p;
      p = h1 & ~h2;
      if (m_phase == 0 && p[0]) begin
        m_a = sw[3:0]; m_err = 1'b0; m_phase = 1;
      end else if (m_phase == 1 && p[1]) begin
        m_b = sw[3:0]; m_phase = 2;
      end else if (m_phase == 2 && p[2]) begin
        if (is_legal(sw)) begin
          m_op = sw; m_err = 1'b0; m_phase = 3;
        end else begin
          m_err = 1'b1;
        end
      end else if (m_phase == 3) begin
        m_leds = alu_f(m_a, m_b, m_op); m_valid = 1'b1; m_phase = 4;
      end else if (m_phase == 4 && p[0]) begin
        m_a = sw[3:0]; m_valid = 1'b0; m_err = 1'b0; m_phase = 1;
      end
      h2 = h1; h1 = h0; h0 = {btn_op, btn_b, btn_a};
    end
  end

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [2:0] m_state;
      m_state = (m_phase < 3) ? (3'b001 << m_phase) : 3'b000;
      cmp("model_alu_a",  {4'h0, alu_a},  {4'h0, m_a});
      cmp("model_alu_b",  {4'h0, alu_b},  {4'h0, m_b});
      cmp("model_alu_op", {2'b00, alu_op}, {2'b00, m_op});
      cmp("model_leds",   {4'h0, leds},   {4'h0, m_leds});
      cmp("model_valid",  {7'h00, valid}, {7'h00, m_valid});
      cmp("model_err",    {7'h00, err},   {7'h00, m_err});
      cmp("model_state",  {5'h00, state}, {5'h00, m_state});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic press(input logic [2:0] btns, input logic [5:0] s);
    sw = s;
    {btn_op, btn_b, btn_a} = btns;
    tick(1);
    {btn_op, btn_b, btn_a} = 3'b000;
    tick(4);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic chk_all_zero(input string tag);
    cmp({tag, "_a"},     {4'h0, alu_a},  8'h00);
    cmp({tag, "_b"},     {4'h0, alu_b},  8'h00);
    cmp({tag, "_op"},    {2'b00, alu_op}, 8'h00);
    cmp({tag, "_leds"},  {4'h0, leds},   8'h00);
    cmp({tag, "_valid"}, {7'h00, valid}, 8'h00);
    cmp({tag, "_err"},   {7'h00, err},   8'h00);
    cmp({tag, "_state"}, {5'h00, state}, 8'h01);
  endtask

  initial begin
    tick(2);
    chk_all_zero("reset");
    rst_n = 1'b1;
    chk_en = 1'b1;
    tick(1);

    // ADD 5 + 3
    press(3'b001, 6'h05);
    press(3'b010, 6'h03);
    press(3'b100, 6'b100000);
    cmp("add_a", {4'h0, alu_a}, 8'h05);
    cmp("add_b", {4'h0, alu_b}, 8'h03);
    cmp("add_leds", {4'h0, leds}, 8'h08);
    cmp("add_valid", {7'h00, valid}, 8'h01);
    cmp("add_state", {5'h00, state}, 8'h00);

    // Reload A from SHOW: valid drops, old result stays; then SUB 3 - 5 wraps
    press(3'b001, 6'h03);
    cmp("reload_valid", {7'h00, valid}, 8'h00);
    cmp("reload_leds", {4'h0, leds}, 8'h08);
    cmp("reload_state", {5'h00, state}, 8'h02);
    press(3'b010, 6'h05);
    press(3'b100, 6'b100010);
    cmp("sub_leds", {4'h0, leds}, 8'h0e);
    cmp("sub_valid", {7'h00, valid}, 8'h01);

    // Illegal opcode then NOR
    press(3'b001, 6'b001010);
    press(3'b010, 6'b000101);
    press(3'b100, 6'b111111);
    cmp("illegal_err", {7'h00, err}, 8'h01);
    cmp("illegal_state", {5'h00, state}, 8'h04);
    cmp("illegal_op", {2'b00, alu_op}, 8'h22);
    press(3'b100, 6'b100111);
    cmp("nor_err", {7'h00, err}, 8'h00);
    cmp("nor_leds", {4'h0, leds}, 8'h00);
    cmp("nor_valid", {7'h00, valid}, 8'h01);
    cmp("nor_op", {2'b00, alu_op}, 8'h27);

    // Wrong buttons in LOAD_A are dropped; simultaneous press loads only A
    do_reset();
    press(3'b010, 6'h07);
    press(3'b100, 6'b100000);
    cmp("drop_state", {5'h00, state}, 8'h01);
    cmp("drop_b", {4'h0, alu_b}, 8'h00);
    press(3'b111, 6'b000110);
    cmp("simul_a", {4'h0, alu_a}, 8'h06);
    cmp("simul_b", {4'h0, alu_b}, 8'h00);
    cmp("simul_op", {2'b00, alu_op}, 8'h00);
    cmp("simul_state", {5'h00, state}, 8'h02);

    // Held A button: one load, exactly at edge t2
    do_reset();
    sw = 6'h09;
    btn_a = 1'b1;
    tick(1);
    cmp("hold_t0", {4'h0, alu_a}, 8'h00);
    tick(1);
    cmp("hold_t1", {4'h0, alu_a}, 8'h00);
    tick(1);
    cmp("hold_t2", {4'h0, alu_a}, 8'h09);
    cmp("hold_state", {5'h00, state}, 8'h02);
    sw = 6'h0c;
    tick(17);
    btn_a = 1'b0;
    tick(4);
    cmp("hold_once_a", {4'h0, alu_a}, 8'h09);
    cmp("hold_once_state", {5'h00, state}, 8'h02);

    // Asynchronous reset while in LOAD_OP
    press(3'b010, 6'h02);
    cmp("pre_rst_state", {5'h00, state}, 8'h04);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick(1);

    // Recovery after reset
    press(3'b001, 6'h07);
    press(3'b010, 6'h01);
    press(3'b100, 6'b100000);
    cmp("recover_leds", {4'h0, leds}, 8'h08);
    cmp("recover_valid", {7'h00, valid}, 8'h01);

    tick(2);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
